// File: rtl/pc_sequencer_pkg.sv
// Shared constants and state encoding for the program-counter sequencer.
//   ADDR_W       : PC / address width
//   RESET_VECTOR : PC value after reset
//   STACK_DEPTH  : entries in the downstream subroutine stack
//   DEPTH_W      : width of the occupancy counter (0..STACK_DEPTH)
package pc_sequencer_pkg;
  localparam int ADDR_W      = 12;
  localparam int STACK_DEPTH = 8;
  localparam int DEPTH_W     = 4;
  localparam logic [ADDR_W-1:0] RESET_VECTOR = 12'h000;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RET_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } seq_state_t;
endpackage

// File: rtl/pc_sequencer_if.sv
// Link between the sequencer and the subroutine stack.
//   subroutine_call   : push strobe (1 cycle)
//   subroutine_return : pop strobe (1 cycle)
//   stack_PC          : value pushed on a call
//   RTS_adr           : popped return address, valid the cycle after the pop edge
// master = sequencer side, slave = stack side.
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;
  logic              subroutine_call;
  logic              subroutine_return;
  logic [ADDR_W-1:0] stack_PC;
  logic [ADDR_W-1:0] RTS_adr;

  modport master (output subroutine_call, subroutine_return, stack_PC,
                  input  RTS_adr);
  modport slave  (input  subroutine_call, subroutine_return, stack_PC,
                  output RTS_adr);
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer feeding a subroutine stack.
//   clock, reset_n        : rising-edge clock, async active-low reset
//   enable                : 1 = advance, 0 = stall everything
//   halt_req/ret/call/jump/branch_taken (+targets) : next-PC requests,
//                           priority halt > ret > call > jump > branch > +1
//   stk                   : push/pop strobes, push value, popped address
//   PC, fetch_valid       : current fetch address and its qualifier
//   depth, stack_error    : stack occupancy and sticky over/underflow flag
//   halted                : high while in HALT (left only by reset)
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 halt_req,
  input  logic                 branch_taken,
  input  logic [ADDR_W-1:0]    branch_target,
  input  logic                 jump,
  input  logic [ADDR_W-1:0]    jump_target,
  input  logic                 call,
  input  logic [ADDR_W-1:0]    call_target,
  input  logic                 ret,
  pc_sequencer_if.master       stk,
  output logic [ADDR_W-1:0]    PC,
  output logic                 fetch_valid,
  output logic [DEPTH_W-1:0]   depth,
  output logic                 stack_error,
  output logic                 halted
);
  seq_state_t          state_q;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_inc;
  logic [DEPTH_W-1:0]  depth_q;
  logic                err_q, halted_q;
  logic                run_go, stk_empty, stk_full;

  assign pc_inc    = pc_q + ADDR_W'(1);
  assign stk_empty = (depth_q == '0);
  assign stk_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
  // reset_n gates the strobes so nothing leaks out while reset is held.
  assign run_go    = reset_n && enable && (state_q == ST_RUN);

  // Strobes are combinational so the stack sees them in the request cycle.
  // ret outranks call, which keeps the two strobes mutually exclusive.
  assign stk.subroutine_return = run_go && !halt_req && ret && !stk_empty;
  assign stk.subroutine_call   = run_go && !halt_req && !ret && call && !stk_full;
  assign stk.stack_PC          = pc_inc;

  assign PC          = pc_q;
  assign fetch_valid = run_go;
  assign depth       = depth_q;
  assign stack_error = err_q;
  assign halted      = halted_q;

  // Next PC while running; rejected ret/call fall through to +1.
  always_comb begin
    pc_d = pc_inc;
    if (halt_req)          pc_d = pc_q;
    else if (ret)          pc_d = stk_empty ? pc_inc : pc_q;
    else if (call)         pc_d = stk_full  ? pc_inc : call_target;
    else if (jump)         pc_d = jump_target;
    else if (branch_taken) pc_d = branch_target;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_RUN;
      pc_q     <= RESET_VECTOR;
      depth_q  <= '0;
      err_q    <= 1'b0;
      halted_q <= 1'b0;
    end else if (enable) begin
      case (state_q)
        ST_RUN: begin
          pc_q <= pc_d;
          if (halt_req) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else if (ret) begin
            if (stk_empty) err_q <= 1'b1;
            else begin
              depth_q <= depth_q - DEPTH_W'(1);
              state_q <= ST_RET_WAIT;
            end
          end else if (call) begin
            if (stk_full) err_q   <= 1'b1;
            else          depth_q <= depth_q + DEPTH_W'(1);
          end
        end
        // Popped address is on RTS_adr now; inputs are ignored here.
        ST_RET_WAIT: begin
          pc_q    <= stk.RTS_adr;
          state_q <= ST_RUN;
        end
        ST_HALT: ;
        default: state_q <= ST_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic clock = 1'b0;
  logic reset_n, enable, halt_req, branch_taken, jump, call, ret;
  logic [ADDR_W-1:0] branch_target, jump_target, call_target, PC;
  logic fetch_valid, stack_error, halted;
  logic [DEPTH_W-1:0] depth;
  int n_chk = 0;
  int n_err = 0;

  pc_sequencer_if stk ();

  pc_sequencer dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .halt_req(halt_req),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .call(call),
    .call_target(call_target), .ret(ret), .stk(stk), .PC(PC),
    .fetch_valid(fetch_valid), .depth(depth), .stack_error(stack_error),
    .halted(halted)
  );

  always #10 clock = ~clock;

  // Behavioural subroutine stack: pop data appears the cycle after the pop edge.
  logic [ADDR_W-1:0] mem [0:15];
  logic [3:0]        sp;
  logic [ADDR_W-1:0] rts_q;
  assign stk.RTS_adr = rts_q;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sp    <= '0;
      rts_q <= '0;
    end else if (stk.subroutine_return) begin
      rts_q <= mem[4'(sp - 4'd1)];
      sp    <= sp - 4'd1;
    end else if (stk.subroutine_call) begin
      mem[sp] <= stk.stack_PC;
      sp      <= sp + 4'd1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    halt_req = 0; branch_taken = 0; jump = 0; call = 0; ret = 0;
  endtask

  task automatic do_jump(input logic [ADDR_W-1:0] t);
    jump = 1; jump_target = t;
    step();
    jump = 0;
  endtask

  task automatic do_ret();
    ret = 1;
    step();
    ret = 0;
    step();
  endtask

  initial begin
    reset_n = 0; enable = 0; clr();
    branch_target = '0; jump_target = '0; call_target = '0;
    #5;
    chk("rst_pc", PC, 0);
    chk("rst_fv", fetch_valid, 0);
    chk("rst_depth", depth, 0);
    chk("rst_err", stack_error, 0);
    chk("rst_halt", halted, 0);
    @(posedge clock); #1;
    reset_n = 1; enable = 1;
    #1;
    chk("run_pc0", PC, 0);
    chk("run_fv", fetch_valid, 1);
    chk("run_strobes", {stk.subroutine_call, stk.subroutine_return}, 0);
    step(); chk("run_pc1", PC, 1);
    step(); step(); chk("run_pc3", PC, 3);

    // single call / return
    do_jump(12'd131);
    chk("jmp_131", PC, 131);
    call = 1; call_target = 12'd696; #1;
    chk("call_strobe", stk.subroutine_call, 1);
    chk("call_stackpc", stk.stack_PC, 132);
    step(); call = 0;
    chk("call_pc", PC, 696);
    chk("call_depth", depth, 1);
    repeat (4) step();
    chk("pc_700", PC, 700);
    ret = 1; #1;
    chk("ret_strobe", stk.subroutine_return, 1);
    chk("ret_nocall", stk.subroutine_call, 0);
    step(); ret = 0;
    chk("ret_bubble_fv", fetch_valid, 0);
    chk("ret_hold_pc", PC, 700);
    chk("ret_depth", depth, 0);
    step();
    chk("ret_pc", PC, 132);
    chk("ret_fv", fetch_valid, 1);

    // nested calls
    do_jump(12'd131);
    call = 1; call_target = 12'd5; step();
    call_target = 12'd40; #1;
    chk("nest_stackpc", stk.stack_PC, 6);
    step(); call = 0;
    chk("nest_pc40", PC, 40);
    chk("nest_depth2", depth, 2);
    do_ret();
    chk("nest_pc6", PC, 6);
    chk("nest_depth1", depth, 1);
    do_ret();
    chk("nest_pc132", PC, 132);
    chk("nest_depth0", depth, 0);

    // underflow
    ret = 1; #1;
    chk("uflow_nostrobe", stk.subroutine_return, 0);
    step(); ret = 0;
    chk("uflow_err", stack_error, 1);
    chk("uflow_pc", PC, 133);

    // overflow: STACK_DEPTH+1 calls
    for (int i = 0; i < STACK_DEPTH; i++) begin
      call = 1; call_target = 12'h100 + 12'(i);
      step();
    end
    chk("oflow_depth8", depth, STACK_DEPTH);
    chk("oflow_pc", PC, 12'h107);
    call_target = 12'h200; #1;
    chk("oflow_nostrobe", stk.subroutine_call, 0);
    step(); call = 0;
    chk("oflow_pc_inc", PC, 12'h108);
    chk("oflow_depth_hold", depth, STACK_DEPTH);
    chk("oflow_err", stack_error, 1);
    for (int i = 0; i < STACK_DEPTH; i++) do_ret();
    chk("drain_pc", PC, 134);
    chk("drain_depth", depth, 0);

    // wrap, call at top of memory, call+ret
    do_jump(12'hFFF);
    step();
    chk("wrap_pc", PC, 0);
    do_jump(12'hFFF);
    call = 1; call_target = 12'd50; #1;
    chk("wrap_stackpc", stk.stack_PC, 0);
    step(); call = 0;
    chk("wrap_call_pc", PC, 50);
    call = 1; ret = 1; #1;
    chk("cr_ret", stk.subroutine_return, 1);
    chk("cr_call", stk.subroutine_call, 0);
    step(); clr();
    chk("cr_depth", depth, 0);
    step();
    chk("cr_pc", PC, 0);

    // jump beats branch, then branch alone
    jump = 1; jump_target = 12'h200; branch_taken = 1; branch_target = 12'h300;
    step(); jump = 0;
    chk("jmp_wins", PC, 12'h200);
    step(); branch_taken = 0;
    chk("branch_pc", PC, 12'h300);

    // stall
    enable = 0; call = 1; call_target = 12'h7; #1;
    chk("stall_nostrobe", stk.subroutine_call, 0);
    step(); call = 0;
    chk("stall_pc", PC, 12'h300);
    chk("stall_fv", fetch_valid, 0);
    enable = 1;

    // reset during RET_WAIT
    call = 1; call_target = 12'h400; step(); call = 0;
    ret = 1; step(); ret = 0;
    chk("rw_fv", fetch_valid, 0);
    reset_n = 0; #1;
    chk("rw_rst_pc", PC, RESET_VECTOR);
    chk("rw_rst_depth", depth, 0);
    chk("rw_rst_err", stack_error, 0);
    chk("rw_rst_fv", fetch_valid, 0);
    reset_n = 1;
    step();
    chk("rw_run_pc", PC, 1);

    // halt
    step();
    halt_req = 1; step(); halt_req = 0;
    chk("halt_flag", halted, 1);
    chk("halt_pc", PC, 2);
    jump = 1; jump_target = 12'h55; call = 1; ret = 1;
    repeat (10) begin
      #1;
      chk("halt_strobes", {stk.subroutine_call, stk.subroutine_return}, 0);
      step();
    end
    clr();
    chk("halt_pc_frozen", PC, 2);
    chk("halt_fv", fetch_valid, 0);
    chk("halt_still", halted, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
